// File: rtl/cpu_run_ctrl.sv
// rtl/cpu_run_ctrl.sv - reset sequencer, halt detector and watchdog for NUM_CORES CPU cores
// Build option RUN_CTRL_AUTOSTART_EN: IDLE advances to HOLD without waiting for start_i.
module cpu_run_ctrl #(
   parameter int NUM_CORES = 1,
   parameter int PC_W      = 16,
   parameter int HOLD_CYC  = 2,
   parameter int TIMEOUT   = 4096,
   parameter int CNT_W     = 32
) (
   input  logic                      clk_i,
   input  logic                      rst_n_i,
   input  logic                      start_i,
   input  logic [NUM_CORES-1:0]      hlt_i,
   input  logic [NUM_CORES*PC_W-1:0] pc_i,
   output logic [NUM_CORES-1:0]      core_rst_n_o,
   output logic                      busy_o,
   output logic                      done_o,
   output logic                      timeout_o,
   output logic [NUM_CORES-1:0]      halted_o,
   output logic [NUM_CORES*PC_W-1:0] last_pc_o,
   output logic [CNT_W-1:0]          cycles_o
);

   localparam int HC_W = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
   localparam logic [HC_W-1:0]  HOLD_LAST = HC_W'(HOLD_CYC - 1);
   localparam logic [HC_W-1:0]  HC_ONE    = HC_W'(1);
   localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
   localparam logic [PC_W-1:0]  PC_ONE    = PC_W'(1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_HOLD,
      ST_RUN,
      ST_DONE
   } state_e;

   state_e                      state_q, state_d;
   logic [HC_W-1:0]             hold_cnt_q, hold_cnt_d;
   logic [CNT_W-1:0]            cycles_q, cycles_d;
   logic [NUM_CORES-1:0]        halted_q, halted_d;
   logic [NUM_CORES*PC_W-1:0]   last_pc_q, last_pc_d;
   logic [NUM_CORES-1:0]        hlt_q, hlt_d;
   logic [NUM_CORES-1:0]        core_rst_n_q, core_rst_n_d;
   logic                        busy_q, busy_d;
   logic                        done_q, done_d;
   logic                        timeout_q, timeout_d;
   logic                        idle_go;
   logic                        enter_hold;

`ifdef RUN_CTRL_AUTOSTART_EN
   assign idle_go = 1'b1;
`else
   assign idle_go = start_i;
`endif

   always_comb begin
      state_d      = state_q;
      hold_cnt_d   = hold_cnt_q;
      cycles_d     = cycles_q;
      halted_d     = halted_q;
      last_pc_d    = last_pc_q;
      hlt_d        = hlt_q;
      core_rst_n_d = core_rst_n_q;
      busy_d       = busy_q;
      done_d       = done_q;
      timeout_d    = timeout_q;
      enter_hold   = 1'b0;

      case (state_q)
         ST_IDLE: enter_hold = idle_go;
         ST_HOLD: begin
            if (hold_cnt_q == HOLD_LAST) begin
               state_d      = ST_RUN;
               core_rst_n_d = '1;
            end else begin
               hold_cnt_d = hold_cnt_q + HC_ONE;
            end
         end
         ST_RUN: begin
            cycles_d = cycles_q + CNT_ONE;
            hlt_d    = hlt_i;
            // Only the first rising hlt per core is captured; pc already points past the hlt.
            for (int i = 0; i < NUM_CORES; i++) begin
               if (hlt_i[i] && !hlt_q[i] && !halted_q[i]) begin
                  halted_d[i]               = 1'b1;
                  last_pc_d[i*PC_W +: PC_W] = pc_i[i*PC_W +: PC_W] - PC_ONE;
               end
            end
            if (&halted_d) begin
               state_d = ST_DONE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
            end else if (cycles_d == CNT_MAX) begin
               state_d   = ST_DONE;
               busy_d    = 1'b0;
               timeout_d = 1'b1;
            end
         end
         ST_DONE: enter_hold = start_i;
         default: state_d = ST_IDLE;
      endcase

      if (enter_hold) begin
         state_d      = ST_HOLD;
         hold_cnt_d   = '0;
         cycles_d     = '0;
         halted_d     = '0;
         last_pc_d    = '0;
         hlt_d        = '0;
         core_rst_n_d = '0;
         busy_d       = 1'b1;
         done_d       = 1'b0;
         timeout_d    = 1'b0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q      <= ST_IDLE;
         hold_cnt_q   <= '0;
         cycles_q     <= '0;
         halted_q     <= '0;
         last_pc_q    <= '0;
         hlt_q        <= '0;
         core_rst_n_q <= '0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         timeout_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         hold_cnt_q   <= hold_cnt_d;
         cycles_q     <= cycles_d;
         halted_q     <= halted_d;
         last_pc_q    <= last_pc_d;
         hlt_q        <= hlt_d;
         core_rst_n_q <= core_rst_n_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         timeout_q    <= timeout_d;
      end
   end

   assign core_rst_n_o = core_rst_n_q;
   assign busy_o       = busy_q;
   assign done_o       = done_q;
   assign timeout_o    = timeout_q;
   assign halted_o     = halted_q;
   assign last_pc_o    = last_pc_q;
   assign cycles_o     = cycles_q;

endmodule
